// File: rtl/freq_meas_sched.sv
// Purpose : scans up to four asynchronous pulse inputs with one shared edge counter and gate timer,
//           publishing the per-channel edge count per gate window, plus a saturation flag.
// Latency : upd[k] is high in cycle SETTLE_CYCLES+GATE_CYCLES+2, counting channel k's first SETTLE cycle as 1.
// Backpressure: none; results are overwritten in place and upd is a one-cycle strobe.
//
// Ports:
//   clk, rst                   system clock, asynchronous active-high reset
//   pulse_sig_1..pulse_sig_4   asynchronous pulse inputs, channels 0..3
//   ch_en[3:0]                 channel enable mask
//   start                      one-cycle scan request (ignored while busy)
//   cont                       continuous scanning while high
//   busy                       high whenever the scheduler is not idle
//   cur_ch[1:0]                channel currently selected
//   freq_out_1..freq_out_4     last completed result per channel (edges per gate window)
//   upd[3:0]                   one-cycle strobe marking a freq_out write
//   ovf[3:0]                   last result of channel k saturated
module freq_meas_sched #(
    parameter int GATE_CYCLES   = 20000000,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_sig_1,
    input  logic             pulse_sig_2,
    input  logic             pulse_sig_3,
    input  logic             pulse_sig_4,
    input  logic [3:0]       ch_en,
    input  logic             start,
    input  logic             cont,
    output logic             busy,
    output logic [1:0]       cur_ch,
    output logic [CNT_W-1:0] freq_out_1,
    output logic [CNT_W-1:0] freq_out_2,
    output logic [CNT_W-1:0] freq_out_3,
    output logic [CNT_W-1:0] freq_out_4,
    output logic [3:0]       upd,
    output logic [3:0]       ovf
);

    localparam int TMR_W = $clog2(GATE_CYCLES + SETTLE_CYCLES + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE,
        ST_NEXT
    } state_t;

    state_t           state_q;
    logic [1:0]       cur_ch_q;
    logic             busy_q;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [3:0]       dly_q;
    logic [3:0]       upd_q;
    logic [3:0]       ovf_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             sat_q;
    logic [TMR_W-1:0] tmr_q;
    logic [CNT_W-1:0] freq_q [4];

    logic [3:0] pulse_in;
    logic [3:0] rise;
    logic [2:0] lowest_d;
    logic [2:0] above_d;

    // Returns {found, index} of the lowest enabled channel at or above 'from'.
    function automatic logic [2:0] pick_from(input logic [3:0] en, input int from);
        logic [2:0] r;
        r = '0;
        for (int k = 3; k >= 0; k--) begin
            if (k >= from && en[k]) begin
                r = {1'b1, k[1:0]};
            end
        end
        return r;
    endfunction

    assign pulse_in = {pulse_sig_4, pulse_sig_3, pulse_sig_2, pulse_sig_1};
    assign rise     = sync2_q & ~dly_q;
    assign lowest_d = pick_from(ch_en, 0);
    // cur_ch = 3 gives from = 4, so no channel is found above it.
    assign above_d  = pick_from(ch_en, int'(cur_ch_q) + 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_ch_q   <= '0;
            busy_q     <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            dly_q      <= '0;
            upd_q      <= '0;
            ovf_q      <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            tmr_q      <= '0;
            for (int k = 0; k < 4; k++) begin
                freq_q[k] <= '0;
            end
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
            upd_q   <= '0;

            case (state_q)
                ST_IDLE: begin
                    if ((start || cont) && lowest_d[2]) begin
                        cur_ch_q <= lowest_d[1:0];
                        tmr_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                    if (!ch_en[cur_ch_q]) begin
                        state_q <= ST_NEXT;
                    end else if (tmr_q == SETTLE_LAST) begin
                        tmr_q   <= '0;
                        state_q <= ST_GATE;
                    end else begin
                        tmr_q <= tmr_q + 1'b1;
                    end
                end

                ST_GATE: begin
                    if (!ch_en[cur_ch_q]) begin
                        // Channel disabled mid-window: the partial count is discarded.
                        state_q <= ST_NEXT;
                    end else begin
                        if (rise[cur_ch_q]) begin
                            if (edge_cnt_q == CNT_MAX) begin
                                sat_q <= 1'b1;
                            end else begin
                                edge_cnt_q <= edge_cnt_q + 1'b1;
                            end
                        end
                        if (tmr_q == GATE_LAST) begin
                            state_q <= ST_STORE;
                        end else begin
                            tmr_q <= tmr_q + 1'b1;
                        end
                    end
                end

                ST_STORE: begin
                    freq_q[cur_ch_q] <= edge_cnt_q;
                    ovf_q[cur_ch_q]  <= sat_q;
                    upd_q[cur_ch_q]  <= 1'b1;
                    state_q          <= ST_NEXT;
                end

                ST_NEXT: begin
                    tmr_q <= '0;
                    if (above_d[2]) begin
                        cur_ch_q <= above_d[1:0];
                        state_q  <= ST_SETTLE;
                    end else if (cont && lowest_d[2]) begin
                        cur_ch_q <= lowest_d[1:0];
                        state_q  <= ST_SETTLE;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign cur_ch     = cur_ch_q;
    assign upd        = upd_q;
    assign ovf        = ovf_q;
    assign freq_out_1 = freq_q[0];
    assign freq_out_2 = freq_q[1];
    assign freq_out_3 = freq_q[2];
    assign freq_out_4 = freq_q[3];

endmodule

// File: tb/tb_freq_meas_sched.sv
// Purpose : directed bench for freq_meas_sched: reset, full scan, continuous scan, saturation,
//           mid-gate abort and mid-gate reset, with hand-computed expected counts.
// Latency : upd checked to arrive in cycle SETTLE+GATE+2 counting the first SETTLE cycle as 1.
// Backpressure: not applicable.
//
// The gate window is shortened to 2000 cycles (100 us) and every input frequency is scaled up
// by 10, so the expected counts equal those of the 1 ms / 20000-cycle case.
// Time unit: clock period is 50 units (20 MHz at 1 unit = 1 ns).
module tb_freq_meas_sched;

    localparam int GATE   = 2000;
    localparam int SETTLE = 4;
    localparam int WIN    = SETTLE + GATE + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_en = 4'h0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        busy;
    logic [1:0]  cur_ch;
    logic [19:0] freq_out_1, freq_out_2, freq_out_3, freq_out_4;
    logic [3:0]  upd;
    logic [3:0]  ovf;

    logic [3:0]  ch_en_s = 4'h0;
    logic        start_s = 1'b0;
    logic        busy_s;
    logic [1:0]  cur_ch_s;
    logic [5:0]  fs_1, fs_2, fs_3, fs_4;
    logic [3:0]  upd_s;
    logic [3:0]  ovf_s;

    // Pulse periods in time units; index 4 feeds the narrow-counter instance. 0 = held low.
    int per [5] = '{30000, 2000, 500, 100000, 500};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int busy_rise_cyc = 0;
    logic busy_prev = 1'b0;
    int upd_log [$];
    int upd_cyc [$];

    for (genvar k = 0; k < 5; k++) begin : g_pg
        logic p = 1'b0;
        always begin
            if (per[k] == 0) begin
                p = 1'b0;
                #100;
            end else begin
                p = 1'b1;
                #(per[k] / 2);
                p = 1'b0;
                #(per[k] - per[k] / 2);
            end
        end
    end

    freq_meas_sched #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(20)) u_dut (
        .clk(clk), .rst(rst),
        .pulse_sig_1(g_pg[0].p), .pulse_sig_2(g_pg[1].p),
        .pulse_sig_3(g_pg[2].p), .pulse_sig_4(g_pg[3].p),
        .ch_en(ch_en), .start(start), .cont(cont),
        .busy(busy), .cur_ch(cur_ch),
        .freq_out_1(freq_out_1), .freq_out_2(freq_out_2),
        .freq_out_3(freq_out_3), .freq_out_4(freq_out_4),
        .upd(upd), .ovf(ovf)
    );

    freq_meas_sched #(.GATE_CYCLES(GATE), .SETTLE_CYCLES(SETTLE), .CNT_W(6)) u_sat (
        .clk(clk), .rst(rst),
        .pulse_sig_1(g_pg[4].p), .pulse_sig_2(1'b0),
        .pulse_sig_3(1'b0), .pulse_sig_4(1'b0),
        .ch_en(ch_en_s), .start(start_s), .cont(1'b0),
        .busy(busy_s), .cur_ch(cur_ch_s),
        .freq_out_1(fs_1), .freq_out_2(fs_2),
        .freq_out_3(fs_3), .freq_out_4(fs_4),
        .upd(upd_s), .ovf(ovf_s)
    );

    always #25 clk = ~clk;

    always @(posedge clk) cyc++;

    // Log every upd strobe (channel and cycle) and the cycle busy last rose.
    always @(negedge clk) begin
        if (busy && !busy_prev) busy_rise_cyc = cyc;
        busy_prev = busy;
        for (int k = 0; k < 4; k++) begin
            if (upd[k]) begin
                upd_log.push_back(k);
                upd_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input int got, input int lo, input int hi);
        n_tests++;
        if (got < lo || got > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", tag, got, lo, hi);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget && busy; i++) tick();
        check(tag, int'(busy), 0, 0);
    endtask

    task automatic wait_ch(input int ch, input int budget, input string tag);
        for (int i = 0; i < budget && int'(cur_ch) != ch; i++) tick();
        check(tag, int'(cur_ch), ch, ch);
    endtask

    function automatic int log_at(input int i);
        return (i < upd_log.size()) ? upd_log[i] : -1;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        tick(3);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_cur_ch", int'(cur_ch), 0, 0);
        check("rst_upd", int'(upd), 0, 0);
        check("rst_ovf", int'(ovf), 0, 0);
        check("rst_freq1", int'(freq_out_1), 0, 0);
        rst = 1'b0;
        tick(20);
        check("idle_after_rst", int'(busy), 0, 0);

        // ---- full single scan, all channels ----
        upd_log.delete();
        upd_cyc.delete();
        ch_en = 4'hF;
        pulse_start();
        wait_idle(4 * WIN + 20, "t1_idle");
        check("t1_n_upd", upd_log.size(), 4, 4);
        for (int i = 0; i < 4; i++) check($sformatf("t1_order%0d", i), log_at(i), i, i);
        check("t1_f1", int'(freq_out_1), 3, 4);
        check("t1_f2", int'(freq_out_2), 49, 51);
        check("t1_f3", int'(freq_out_3), 199, 201);
        check("t1_f4", int'(freq_out_4), 0, 2);
        check("t1_ovf", int'(ovf), 0, 0);
        if (upd_cyc.size() > 0)
            check("t1_latency", upd_cyc[0] - busy_rise_cyc + 1, WIN, WIN);

        // ---- abort: drop channel 1 midway through its gate ----
        upd_log.delete();
        pulse_start();
        wait_ch(1, 2 * WIN + 20, "t4_reach1");
        tick(SETTLE + GATE / 2);
        ch_en = 4'b1101;
        wait_idle(3 * WIN + 20, "t4_idle");
        check("t4_n_upd", upd_log.size(), 3, 3);
        check("t4_order0", log_at(0), 0, 0);
        check("t4_order1", log_at(1), 2, 2);
        check("t4_order2", log_at(2), 3, 3);
        check("t4_f2_held", int'(freq_out_2), 49, 51);

        // ---- continuous scan over channels 0 and 2 ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        upd_log.delete();
        ch_en = 4'b0101;
        cont = 1'b1;
        for (int i = 0; i < 4 * WIN && upd_log.size() < 3; i++) tick();
        cont = 1'b0;
        wait_idle(2 * WIN + 20, "t2_idle");
        check("t2_n_upd", upd_log.size(), 4, 4);
        check("t2_order0", log_at(0), 0, 0);
        check("t2_order1", log_at(1), 2, 2);
        check("t2_order2", log_at(2), 0, 0);
        check("t2_order3", log_at(3), 2, 2);
        check("t2_f2_zero", int'(freq_out_2), 0, 0);
        check("t2_f4_zero", int'(freq_out_4), 0, 0);
        check("t2_f1", int'(freq_out_1), 3, 4);
        check("t2_f3", int'(freq_out_3), 199, 201);

        // ---- saturation on a 6-bit counter, then a normal window ----
        ch_en_s = 4'b0001;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < WIN + 20 && busy_s; i++) tick();
        check("t3_idle_a", int'(busy_s), 0, 0);
        check("t3_sat_val", int'(fs_1), 63, 63);
        check("t3_sat_ovf", int'(ovf_s[0]), 1, 1);
        per[4] = 30000;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int i = 0; i < WIN + 20 && busy_s; i++) tick();
        check("t3_idle_b", int'(busy_s), 0, 0);
        check("t3_norm_val", int'(fs_1), 3, 4);
        check("t3_norm_ovf", int'(ovf_s[0]), 0, 0);

        // ---- reset asserted mid-gate ----
        ch_en = 4'hF;
        pulse_start();
        wait_ch(2, 3 * WIN + 20, "t5_reach2");
        tick(SETTLE + GATE / 2);
        rst = 1'b1;
        #1;
        check("t5_busy", int'(busy), 0, 0);
        check("t5_cur_ch", int'(cur_ch), 0, 0);
        check("t5_upd", int'(upd), 0, 0);
        check("t5_ovf", int'(ovf), 0, 0);
        check("t5_f1", int'(freq_out_1), 0, 0);
        check("t5_f2", int'(freq_out_2), 0, 0);
        check("t5_f3", int'(freq_out_3), 0, 0);
        check("t5_f4", int'(freq_out_4), 0, 0);
        tick();
        rst = 1'b0;
        ch_en = 4'h0;
        tick();
        upd_log.delete();
        pulse_start();
        begin
            int busy_seen;
            busy_seen = 0;
            for (int i = 0; i < 20; i++) begin
                if (busy) busy_seen++;
                tick();
            end
            check("t5_no_en_busy", busy_seen, 0, 0);
        end
        check("t5_no_en_upd", upd_log.size(), 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
